rbm_main: RTL and testbench

// - Stochastic RBM inference engine: a serial hidden-layer neuron (784 pixels + bias -> 441 hidden bits)
//   and a serial classifier neuron (441 hidden bits + bias -> 10 spike bits).
// - A controller streams one weight/input pair per clock; the engine accumulates and fires a Bernoulli

---
 rtl/rbm_main.sv | 124 ++++++++++++
 tb/tb_rbm_main.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbm_main.sv
// Stochastic RBM inference engine: serial hidden neuron (784 pixels + bias) and serial class neuron (441 + bias).
// Optional DETERMINISTIC_EN: sample = (sum >= 0) instead of sigmoid probability vs LFSR.
module rbm_main #(
   parameter int unsigned W_WIDTH    = 12,
   parameter int unsigned ACC_WIDTH  = 22,
   parameter int unsigned APPROX_LSB = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [W_WIDTH-1:0] Hvalue,
   input  logic [9:0]         pixel_id,
   input  logic               pixel,
   input  logic               hidden_switch,
   input  logic               enable_hidden,
   input  logic               enable_classi,
   input  logic [W_WIDTH-1:0] Cvalue,
   input  logic [8:0]         hidden_id,
   input  logic               hidden_pixel,
   output logic               hidden,
   output logic               hidden_finish,
   output logic               spike,
   output logic               finish
);

   localparam int unsigned EXT_W = ACC_WIDTH - W_WIDTH;
   localparam logic [9:0]  HID_BIAS_ID = 10'd784;
   localparam logic [8:0]  CLS_BIAS_ID = 9'd441;
   localparam logic [ACC_WIDTH-1:0] APPROX_MASK = ~ACC_WIDTH'((32'd1 << APPROX_LSB) - 32'd1);

   logic [15:0]                 lfsr_q, lfsr_d;
   logic signed [ACC_WIDTH-1:0] acc_h_q, acc_h_d, acc_c_q, acc_c_d;
   logic                        hidden_q, hidden_d, hidden_finish_q, hidden_finish_d;
   logic                        spike_q, spike_d, finish_q, finish_d;

   logic signed [ACC_WIDTH-1:0] term_h, sum_raw_h, sum_h, term_c, sum_c;
   logic                        samp_h, samp_c;

   // Gated, sign-extended terms and running sums; the hidden sum may drop its low bits.
   assign term_h    = pixel ? {{EXT_W{Hvalue[W_WIDTH-1]}}, Hvalue} : '0;
   assign term_c    = hidden_pixel ? {{EXT_W{Cvalue[W_WIDTH-1]}}, Cvalue} : '0;
   assign sum_raw_h = acc_h_q + term_h;
   assign sum_h     = hidden_switch ? sum_raw_h : (sum_raw_h & APPROX_MASK);
   assign sum_c     = acc_c_q + term_c;

`ifdef DETERMINISTIC_EN
   assign samp_h = ~sum_h[ACC_WIDTH-1];
   assign samp_c = ~sum_c[ACC_WIDTH-1];
`else
   localparam logic signed [ACC_WIDTH-1:0] SIG_HI = ACC_WIDTH'(1024);
   localparam logic signed [ACC_WIDTH-1:0] SIG_LO = ACC_WIDTH'(-1024);

   // Piecewise-linear sigmoid on Q4.8: 128 + x*32, clipped at |x| >= 4.
   function automatic logic [7:0] sigmoid(input logic signed [ACC_WIDTH-1:0] s);
      logic signed [ACC_WIDTH-1:0] lin;
      lin = (s >>> 3) + ACC_WIDTH'(128);
      if (s <= SIG_LO) return 8'd0;
      if (s >= SIG_HI) return 8'hFF;
      return 8'(lin);
   endfunction

   assign samp_h = lfsr_q[7:0] < sigmoid(sum_h);
   assign samp_c = lfsr_q[7:0] < sigmoid(sum_c);
`endif

   // Index-driven restart / accumulate / fire for both neurons.
   always_comb begin
      lfsr_d          = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      acc_h_d         = acc_h_q;
      hidden_d        = hidden_q;
      hidden_finish_d = 1'b0;
      acc_c_d         = acc_c_q;
      spike_d         = spike_q;
      finish_d        = 1'b0;

      if (enable_hidden) begin
         if (pixel_id == '0) begin
            acc_h_d = term_h;
         end else if (pixel_id < HID_BIAS_ID) begin
            acc_h_d = sum_h;
         end else if (pixel_id == HID_BIAS_ID) begin
            hidden_d        = samp_h;
            hidden_finish_d = 1'b1;
         end
      end

      if (enable_classi) begin
         if (hidden_id == '0) begin
            acc_c_d = term_c;
         end else if (hidden_id < CLS_BIAS_ID) begin
            acc_c_d = sum_c;
         end else if (hidden_id == CLS_BIAS_ID) begin
            spike_d  = samp_c;
            finish_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q          <= LFSR_SEED;
         acc_h_q         <= '0;
         hidden_q        <= 1'b0;
         hidden_finish_q <= 1'b0;
         acc_c_q         <= '0;
         spike_q         <= 1'b0;
         finish_q        <= 1'b0;
      end else begin
         lfsr_q          <= lfsr_d;
         acc_h_q         <= acc_h_d;
         hidden_q        <= hidden_d;
         hidden_finish_q <= hidden_finish_d;
         acc_c_q         <= acc_c_d;
         spike_q         <= spike_d;
         finish_q        <= finish_d;
      end
   end

   assign hidden        = hidden_q;
   assign hidden_finish = hidden_finish_q;
   assign spike         = spike_q;
   assign finish        = finish_q;

endmodule

// File: tb/tb_rbm_main.sv
// Self-checking bench for rbm_main: full neuron sweeps against an arithmetic reference of the sum and sampler.
module tb_rbm_main;

   logic        clock, reset;
   logic [11:0] Hvalue, Cvalue;
   logic [9:0]  pixel_id;
   logic [8:0]  hidden_id;
   logic        pixel, hidden_switch, enable_hidden, enable_classi, hidden_pixel;
   logic        hidden, hidden_finish, spike, finish;

   rbm_main dut (
      .clock(clock), .reset(reset), .Hvalue(Hvalue), .pixel_id(pixel_id), .pixel(pixel),
      .hidden_switch(hidden_switch), .enable_hidden(enable_hidden), .enable_classi(enable_classi),
      .Cvalue(Cvalue), .hidden_id(hidden_id), .hidden_pixel(hidden_pixel),
      .hidden(hidden), .hidden_finish(hidden_finish), .spike(spike), .finish(finish)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   logic [11:0] hw [785];
   logic        hp [785];
   logic [11:0] cw [442];
   logic        cp [442];

   // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded on reset.
   logic [15:0] m_lfsr;
   always @(posedge clock or negedge reset) begin
      if (!reset) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic int floor16(input int v);
      return (v >= 0) ? (v / 16) * 16 : -(((-v + 15) / 16) * 16);
   endfunction

   function automatic int hid_sum(input bit sw);
      int acc;
      int t;
      acc = 0;
      for (int i = 0; i < 785; i++) begin
         t = hp[i] ? int'($signed(hw[i])) : 0;
         if (i == 0) acc = t;
         else begin
            acc = acc + t;
            if (!sw) acc = floor16(acc);
         end
      end
      return acc;
   endfunction

   function automatic int cls_sum();
      int acc;
      acc = 0;
      for (int i = 0; i < 442; i++) acc += cp[i] ? int'($signed(cw[i])) : 0;
      return acc;
   endfunction

   function automatic logic exp_sample(input int s, input logic [7:0] rnd);
`ifdef DETERMINISTIC_EN
      logic unused_rnd;
      unused_rnd = ^rnd;
      return s >= 0;
`else
      int p;
      if (s <= -1024)     p = 0;
      else if (s >= 1024) p = 255;
      else                p = 128 + ((s >= 0) ? s / 8 : -((-s + 7) / 8));
      return int'(rnd) < p;
`endif
   endfunction

   // Drives one sweep (hidden, classifier or both); optionally inserts an out-of-range and a disabled cycle.
   task automatic sweep(input bit do_h, input bit do_c, input bit sw, input bit perturb,
                        output int pulse_err, output logic got_h, output logic got_c,
                        output logic [7:0] rnd_h, output logic [7:0] rnd_c);
      int n;
      logic hf_exp, f_exp;
      n = do_h ? 785 : 442;
      pulse_err = 0; got_h = 1'b0; got_c = 1'b0; rnd_h = '0; rnd_c = '0;
      for (int k = 0; k < n; k++) begin
         if (perturb && k == 300) begin
            enable_hidden = do_h; enable_classi = do_c;
            pixel_id = 10'd1000; hidden_id = 9'd500; pixel = 1'b1; hidden_pixel = 1'b1;
            Hvalue = 12'($urandom); Cvalue = 12'($urandom);
            @(posedge clock); @(negedge clock);
            if (hidden_finish !== 1'b0 || finish !== 1'b0) pulse_err++;
            enable_hidden = 1'b0; enable_classi = 1'b0; pixel_id = '0; hidden_id = '0;
            @(posedge clock); @(negedge clock);
            if (hidden_finish !== 1'b0 || finish !== 1'b0) pulse_err++;
         end
         enable_hidden = do_h; pixel_id = 10'(k); pixel = hp[k]; Hvalue = hw[k]; hidden_switch = sw;
         if (do_c && k < 442) begin
            enable_classi = 1'b1; hidden_id = 9'(k); hidden_pixel = cp[k]; Cvalue = cw[k];
         end else begin
            enable_classi = 1'b0; hidden_id = '0; hidden_pixel = 1'b0; Cvalue = '0;
         end
         if (k == 784) rnd_h = m_lfsr[7:0];
         if (k == 441) rnd_c = m_lfsr[7:0];
         @(posedge clock); @(negedge clock);
         hf_exp = do_h && (k == 784);
         f_exp  = do_c && (k == 441);
         if (hidden_finish !== hf_exp || finish !== f_exp) pulse_err++;
         if (hf_exp) got_h = hidden;
         if (f_exp)  got_c = spike;
      end
      enable_hidden = 1'b0; enable_classi = 1'b0;
   endtask

   task automatic test_hidden_case(input string name, input bit sw, input bit perturb);
      int s, perr;
      logic gh, gc, exp_h, c_before;
      logic [7:0] rh, rc;
      s = hid_sum(sw);
      c_before = spike;
      sweep(1'b1, 1'b0, sw, perturb, perr, gh, gc, rh, rc);
      exp_h = exp_sample(s, rh);
      n_tests++;
      if (perr != 0) begin
         n_fail++; $display("FAIL %s pulses: %0d bad cycles, required 0", name, perr);
      end
      n_tests++;
      if (gh !== exp_h) begin
         n_fail++; $display("FAIL %s hidden: got %b required %b (sum %0d)", name, gh, exp_h, s);
      end
      @(posedge clock); @(negedge clock);
      n_tests++;
      if (hidden !== exp_h || hidden_finish !== 1'b0 || spike !== c_before) begin
         n_fail++;
         $display("FAIL %s hold: hidden=%b pulse=%b spike=%b required %b 0 %b",
                  name, hidden, hidden_finish, spike, exp_h, c_before);
      end
   endtask

   task automatic test_class_case(input string name, input bit perturb);
      int s, perr;
      logic gh, gc, exp_c, h_before;
      logic [7:0] rh, rc;
      s = cls_sum();
      h_before = hidden;
      sweep(1'b0, 1'b1, 1'b1, perturb, perr, gh, gc, rh, rc);
      exp_c = exp_sample(s, rc);
      n_tests++;
      if (perr != 0) begin
         n_fail++; $display("FAIL %s pulses: %0d bad cycles, required 0", name, perr);
      end
      n_tests++;
      if (gc !== exp_c) begin
         n_fail++; $display("FAIL %s spike: got %b required %b (sum %0d)", name, gc, exp_c, s);
      end
      @(posedge clock); @(negedge clock);
      n_tests++;
      if (spike !== exp_c || finish !== 1'b0 || hidden !== h_before) begin
         n_fail++;
         $display("FAIL %s hold: spike=%b finish=%b hidden=%b required %b 0 %b",
                  name, spike, finish, hidden, exp_c, h_before);
      end
   endtask

   task automatic rand_hidden();
      for (int i = 0; i < 784; i++) begin
         hp[i] = 1'($urandom);
         hw[i] = 12'($urandom_range(0, 80)) - 12'd40;
      end
      hp[784] = 1'b1;
      hw[784] = 12'($urandom_range(0, 2047)) - 12'd1024;
   endtask

   task automatic rand_class();
      for (int i = 0; i < 441; i++) begin
         cp[i] = 1'($urandom);
         cw[i] = 12'($urandom_range(0, 80)) - 12'd40;
      end
      cp[441] = 1'b1;
      cw[441] = 12'($urandom_range(0, 2047)) - 12'd1024;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      enable_hidden = 1'b0; enable_classi = 1'b0; pixel_id = '0; hidden_id = '0;
      pixel = 1'b0; hidden_pixel = 1'b0; Hvalue = '0; Cvalue = '0; hidden_switch = 1'b1;
      repeat (3) @(negedge clock);
      n_tests++;
      if (hidden !== 1'b0 || spike !== 1'b0) begin
         n_fail++; $display("FAIL reset outputs: hidden=%b spike=%b required 0 0", hidden, spike);
      end
      n_tests++;
      if (hidden_finish !== 1'b0 || finish !== 1'b0) begin
         n_fail++; $display("FAIL reset pulses: %b %b required 0 0", hidden_finish, finish);
      end
      enable_hidden = 1'b1; pixel_id = 10'd784; pixel = 1'b1; Hvalue = 12'h7FF;
      enable_classi = 1'b1; hidden_id = 9'd441; hidden_pixel = 1'b1; Cvalue = 12'h7FF;
      @(posedge clock); @(negedge clock);
      n_tests++;
      if (hidden_finish !== 1'b0 || finish !== 1'b0 || hidden !== 1'b0 || spike !== 1'b0) begin
         n_fail++; $display("FAIL reset held fire: %b %b %b %b required 0 0 0 0",
                            hidden_finish, finish, hidden, spike);
      end
      enable_hidden = 1'b0; enable_classi = 1'b0;
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_hidden_directed();
      for (int i = 0; i < 784; i++) begin hp[i] = 1'b1; hw[i] = 12'h001; end
      hp[784] = 1'b1; hw[784] = 12'hCE0;
      test_hidden_case("h_bias_m800", 1'b1, 1'b0);
      hw[784] = 12'hCF0;
      test_hidden_case("h_bias_m784", 1'b1, 1'b0);
      for (int i = 0; i < 784; i++) begin hp[i] = 1'b0; hw[i] = 12'($urandom); end
      hw[784] = 12'h001;
      test_hidden_case("h_trunc_plus1", 1'b0, 1'b0);
      hw[784] = 12'hFF0;
      test_hidden_case("h_exact_m16", 1'b1, 1'b0);
   endtask

   task automatic test_class_directed();
      for (int i = 0; i < 441; i++) begin cp[i] = 1'b1; cw[i] = 12'hFFF; end
      cp[441] = 1'b1; cw[441] = 12'd441;
      test_class_case("c_bias_441", 1'b0);
      cw[441] = 12'd440;
      test_class_case("c_bias_440", 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         rand_hidden();
         test_hidden_case($sformatf("h_rand%0d", r), 1'($urandom), (r == 1));
      end
      for (int r = 0; r < 4; r++) begin
         rand_class();
         test_class_case($sformatf("c_rand%0d", r), (r == 2));
      end
   endtask

   task automatic test_back_to_back();
      int sh, sc, perr;
      logic gh, gc, eh, ec;
      logic [7:0] rh, rc;
      rand_hidden();
      rand_class();
      sh = hid_sum(1'b0);
      sc = cls_sum();
      sweep(1'b1, 1'b1, 1'b0, 1'b1, perr, gh, gc, rh, rc);
      eh = exp_sample(sh, rh);
      ec = exp_sample(sc, rc);
      n_tests++;
      if (perr != 0) begin
         n_fail++; $display("FAIL both pulses: %0d bad cycles, required 0", perr);
      end
      n_tests++;
      if (gh !== eh || gc !== ec) begin
         n_fail++; $display("FAIL both values: hidden=%b spike=%b required %b %b", gh, gc, eh, ec);
      end
   endtask

   task automatic test_reset_mid();
      rand_class();
      cw[441] = 12'h7FF;
      test_class_case("c_pre_reset", 1'b0);
      rand_hidden();
      for (int k = 0; k < 100; k++) begin
         enable_hidden = 1'b1; pixel_id = 10'(k); pixel = hp[k]; Hvalue = hw[k];
         hidden_switch = 1'b1;
         @(posedge clock); @(negedge clock);
      end
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if (hidden !== 1'b0 || spike !== 1'b0 || hidden_finish !== 1'b0 || finish !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid async: %b %b %b %b required 0 0 0 0",
                            hidden, spike, hidden_finish, finish);
      end
      enable_hidden = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      rand_hidden();
      test_hidden_case("h_after_reset", 1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_hidden_directed();
      test_class_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
